// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its issue control.
// Op select is one-hot, bit 0 = mul through bit 7 = remu.
package mdu_pkg;

  localparam int MDU_OP_W = 8;

  localparam int MDU_MUL    = 0;
  localparam int MDU_MULH   = 1;
  localparam int MDU_MULHU  = 2;
  localparam int MDU_MULHSU = 3;
  localparam int MDU_DIV    = 4;
  localparam int MDU_DIVU   = 5;
  localparam int MDU_REM    = 6;
  localparam int MDU_REMU   = 7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_onehot8(
    input logic [MDU_OP_W-1:0] op
  );
    return (op != '0) &&
           ((op & (op - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Request, result and MDU-side bundles of the issue controller.
// slave is the controller, master is the pipeline plus MDU around it.
interface mdu_issue_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  import mdu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MDU_OP_W-1:0] in_op;
  logic [XLEN-1:0]     in_src1;
  logic [XLEN-1:0]     in_src2;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [TAG_W-1:0]    out_tag;
  logic                out_err;

  logic [MDU_OP_W-1:0] mdu_op;
  logic [XLEN-1:0]     mdu_src1;
  logic [XLEN-1:0]     mdu_src2;
  logic                mdu_flush;
  logic [XLEN-1:0]     mdu_result;
  logic                mdu_ready;

  modport slave (
    input  in_valid, in_op, in_src1,
    input  in_src2, in_tag, out_ready,
    input  mdu_result, mdu_ready,
    output in_ready, out_valid, out_result,
    output out_tag, out_err, mdu_op,
    output mdu_src1, mdu_src2, mdu_flush
  );

  modport master (
    output in_valid, in_op, in_src1,
    output in_src2, in_tag, out_ready,
    output mdu_result, mdu_ready,
    input  in_ready, out_valid, out_result,
    input  out_tag, out_err, mdu_op,
    input  mdu_src1, mdu_src2, mdu_flush
  );

endinterface

// File: rtl/mdu_watchdog.sv
// BUSY-cycle counter for the MDU issue controller.
// expire pulses in the TIMEOUT-th enabled cycle; TIMEOUT=0 disables.
module mdu_watchdog #(
  parameter int TIMEOUT = 128
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // count enabled cycles, saturating at TIMEOUT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIM) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && en &&
                  (cnt == LAST);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Execute-stage issue control for the MDU: one op in flight,
// operands held until mdu_ready, result returned with its tag.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  mdu_issue_ctrl_if.slave  io
);

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_err_q;
  logic                mdu_flush_q;
  logic [XLEN-1:0]     out_result_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic [MDU_OP_W-1:0] mdu_op_q;
  logic [XLEN-1:0]     src1_q;
  logic [XLEN-1:0]     src2_q;
  logic                accept;
  logic                busy;
  logic                expire;

  assign accept = (state == IDLE) && in_ready_q &&
                  io.in_valid && !flush;
  assign busy   = (state == BUSY);

  mdu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clr    (accept),
    .en     (busy),
    .expire (expire)
  );

  // issue FSM with all outputs registered; flush wins over everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      mdu_flush_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      mdu_op_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
    end else begin
      mdu_flush_q <= 1'b0;
      if (flush) begin
        state        <= IDLE;
        in_ready_q   <= 1'b1;
        out_valid_q  <= 1'b0;
        out_err_q    <= 1'b0;
        out_result_q <= '0;
        mdu_op_q     <= '0;
        mdu_flush_q  <= busy;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              in_ready_q <= 1'b0;
              out_tag_q  <= io.in_tag;
              if (is_onehot8(io.in_op)) begin
                state    <= BUSY;
                mdu_op_q <= io.in_op;
                src1_q   <= io.in_src1;
                src2_q   <= io.in_src2;
              end else begin
                state        <= DONE;
                out_valid_q  <= 1'b1;
                out_err_q    <= 1'b1;
                out_result_q <= '0;
              end
            end else begin
              in_ready_q <= 1'b1;
            end
          end
          BUSY: begin
            if (io.mdu_ready) begin
              state        <= DONE;
              mdu_op_q     <= '0;
              out_valid_q  <= 1'b1;
              out_err_q    <= 1'b0;
              out_result_q <= io.mdu_result;
            end else if (expire) begin
              state        <= DONE;
              mdu_op_q     <= '0;
              mdu_flush_q  <= 1'b1;
              out_valid_q  <= 1'b1;
              out_err_q    <= 1'b1;
              out_result_q <= '0;
            end
          end
          DONE: begin
            if (io.out_ready) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_tag    = out_tag_q;
  assign io.out_err    = out_err_q;
  assign io.mdu_op     = mdu_op_q;
  assign io.mdu_src1   = src1_q;
  assign io.mdu_src2   = src2_q;
  assign io.mdu_flush  = mdu_flush_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: vector table plus
// hand sequences for flush, timeout and reset corners.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int TO = 16;
  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  mdu_issue_ctrl_if #(.XLEN(64), .TAG_W(5)) bus ();

  mdu_issue_ctrl #(
    .XLEN    (64),
    .TAG_W   (5),
    .TIMEOUT (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .io    (bus.slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    int          lat;
    int          hold;
    logic [63:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [7:0] oh(input int b);
    logic [7:0] one;
    one = 8'd1;
    return one << b;
  endfunction

  // reference M-extension behaviour used as the MDU model
  function automatic logic [63:0] ref_mdu(
    input logic [7:0]  op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [127:0] p;
    logic [63:0]  mn;
    logic [63:0]  r;
    mn = 64'h8000_0000_0000_0000;
    r  = '0;
    unique case (1'b1)
      op[MDU_MUL]: r = a * b;
      op[MDU_MULH]: begin
        p = $signed({{64{a[63]}}, a}) *
            $signed({{64{b[63]}}, b});
        r = p[127:64];
      end
      op[MDU_MULHU]: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[127:64];
      end
      op[MDU_MULHSU]: begin
        p = $signed({{64{a[63]}}, a}) *
            $signed({64'd0, b});
        r = p[127:64];
      end
      op[MDU_DIV]:
        if (b == 0) r = ONES;
        else if (a == mn && b == ONES) r = a;
        else r = $signed(a) / $signed(b);
      op[MDU_DIVU]:
        r = (b == 0) ? ONES : a / b;
      op[MDU_REM]:
        if (b == 0) r = a;
        else if (a == mn && b == ONES) r = '0;
        else r = $signed(a) % $signed(b);
      op[MDU_REMU]:
        r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic start(
    input logic [7:0]  op,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [4:0]  tag
  );
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("idle_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = tag;
    step();
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bit ok;
    bit fl;
    int seen;
    int k;
    start(v.op, v.a, v.b, v.tag);
    if (!is_onehot8(v.op)) begin
      chk($sformatf("v%0d_ill_op", i),
          64'(bus.mdu_op), 64'd0);
      chk($sformatf("v%0d_ill_valid", i),
          64'(bus.out_valid), 64'd1);
    end else begin
      ok = 1'b1;
      fl = 1'b0;
      seen = 0;
      k = 1;
      while (k <= 40 && seen == 0) begin
        if (bus.mdu_op !== v.op ||
            bus.mdu_src1 !== v.a ||
            bus.mdu_src2 !== v.b)
          ok = 1'b0;
        if (k == v.lat) begin
          bus.mdu_ready  = 1'b1;
          bus.mdu_result = ref_mdu(v.op, v.a, v.b);
        end
        step();
        bus.mdu_ready  = 1'b0;
        bus.mdu_result = JUNK;
        if (bus.out_valid === 1'b1) begin
          seen = k;
          fl   = bus.mdu_flush;
        end
        k++;
      end
      chk($sformatf("v%0d_stable", i), 64'(ok), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(seen),
          64'((v.lat == 0) ? TO : v.lat));
      chk($sformatf("v%0d_mdu_flush", i), 64'(fl),
          64'(v.lat == 0));
      chk($sformatf("v%0d_op_clr", i),
          64'(bus.mdu_op), 64'd0);
    end
    ok = 1'b1;
    bus.out_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = oh(MDU_MUL);
      step();
      if (bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 ||
          bus.out_result !== v.res ||
          bus.out_tag !== v.tag ||
          bus.mdu_op !== 8'd0 ||
          bus.mdu_flush !== 1'b0)
        ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    chk($sformatf("v%0d_hold", i), 64'(ok), 64'd1);
    chk($sformatf("v%0d_result", i),
        bus.out_result, v.res);
    chk($sformatf("v%0d_tag", i),
        64'(bus.out_tag), 64'(v.tag));
    chk($sformatf("v%0d_err", i),
        64'(bus.out_err), 64'(v.err));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d_release", i),
        {62'd0, bus.out_valid, bus.in_ready},
        64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_src1    = '0;
    bus.in_src2    = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b0;
    bus.mdu_ready  = 1'b0;
    bus.mdu_result = JUNK;

    tbl[0]  = '{oh(MDU_MUL), 64'd3, 64'd5, 5'd7,
                1, 0, 64'd15, 1'b0};
    tbl[1]  = '{oh(MDU_DIV), -64'sd7, 64'd0, 5'd3,
                10, 0, ONES, 1'b0};
    tbl[2]  = '{oh(MDU_MULHU), ONES, ONES, 5'd9,
                3, 5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[3]  = '{oh(MDU_REM), -64'sd7, 64'd2, 5'd1,
                2, 1, ONES, 1'b0};
    tbl[4]  = '{oh(MDU_MULH), ONES, ONES, 5'd2,
                1, 0, 64'd0, 1'b0};
    tbl[5]  = '{oh(MDU_DIVU), 64'd100, 64'd7, 5'd4,
                4, 0, 64'd14, 1'b0};
    tbl[6]  = '{oh(MDU_REMU), 64'd100, 64'd7, 5'd5,
                4, 0, 64'd2, 1'b0};
    tbl[7]  = '{oh(MDU_MULHSU), ONES, 64'd2, 5'd6,
                2, 0, ONES, 1'b0};
    tbl[8]  = '{oh(MDU_DIV), 64'h8000_0000_0000_0000,
                ONES, 5'd8, 3, 0,
                64'h8000_0000_0000_0000, 1'b0};
    tbl[9]  = '{oh(MDU_MULHU), 64'd1, 64'd1, 5'd10,
                0, 2, 64'd0, 1'b1};
    tbl[10] = '{8'b0000_0011, 64'd1, 64'd2, 5'd11,
                0, 1, 64'd0, 1'b1};
    tbl[11] = '{8'b0000_0000, 64'd1, 64'd2, 5'd12,
                0, 0, 64'd0, 1'b1};

    #2 reset = 1'b0;
    #2;
    chk("rst_outputs",
        {bus.in_ready, bus.out_valid, bus.out_err,
         bus.mdu_flush, bus.mdu_op, bus.out_tag},
        64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    step();
    reset = 1'b1;
    chk("rst_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    chk("rst_ready_rise", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    // flush in the 3rd BUSY cycle of a divu
    start(oh(MDU_DIVU), 64'd9, 64'd3, 5'd13);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_pulse", 64'(bus.mdu_flush), 64'd1);
    chk("fl_op_clr", 64'(bus.mdu_op), 64'd0);
    chk("fl_no_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("fl_pulse_end", 64'(bus.mdu_flush), 64'd0);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);

    // flush beats a simultaneous mdu_ready
    start(oh(MDU_MUL), 64'd3, 64'd5, 5'd14);
    flush          = 1'b1;
    bus.mdu_ready  = 1'b1;
    bus.mdu_result = 64'd15;
    step();
    flush          = 1'b0;
    bus.mdu_ready  = 1'b0;
    bus.mdu_result = JUNK;
    chk("flr_pulse", 64'(bus.mdu_flush), 64'd1);
    chk("flr_no_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("flr_result", bus.out_result, 64'd0);

    // flush beats out_ready in DONE; no mdu_flush from DONE
    start(oh(MDU_MUL), 64'd3, 64'd5, 5'd15);
    bus.mdu_ready  = 1'b1;
    bus.mdu_result = 64'd15;
    step();
    bus.mdu_ready  = 1'b0;
    bus.mdu_result = JUNK;
    chk("fld_valid", 64'(bus.out_valid), 64'd1);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    chk("fld_state",
        {61'd0, bus.out_valid, bus.mdu_flush,
         bus.in_ready}, 64'd1);
    chk("fld_result", bus.out_result, 64'd0);

    // flush coinciding with the watchdog expiry
    start(oh(MDU_DIV), 64'd1, 64'd1, 5'd16);
    for (int k = 1; k < TO; k++) step();
    chk("flt_pre", 64'(bus.out_valid), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flt_pulse", 64'(bus.mdu_flush), 64'd1);
    chk("flt_no_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("flt_after",
        {62'd0, bus.mdu_flush, bus.out_valid},
        64'd0);

    // flush in IDLE blocks a request
    step();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = oh(MDU_MUL);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    chk("fli_no_issue", 64'(bus.mdu_op), 64'd0);
    step();
    chk("fli_idle",
        {62'd0, bus.out_valid, bus.in_ready},
        64'd1);

    // async reset in the middle of BUSY
    start(oh(MDU_MUL), ONES, ONES, 5'd17);
    step();
    chk("rb_busy", 64'(bus.mdu_op), 64'(oh(MDU_MUL)));
    reset = 1'b0;
    #1;
    chk("rb_outputs",
        {bus.in_ready, bus.out_valid, bus.out_err,
         bus.mdu_flush, bus.mdu_op, bus.out_tag},
        64'd0);
    chk("rb_src1", bus.mdu_src1, 64'd0);
    step();
    chk("rb_no_flush", 64'(bus.mdu_flush), 64'd0);
    reset = 1'b1;
    step();
    chk("rb_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
